// File: rtl/rda_pipe_adder_pkg.sv
// Shared KPG symbol type, encodings and helpers for the recursive-doubling adder.
package rda_pkg;

   typedef logic [1:0] kpg_t;

   localparam kpg_t KPG_K = 2'b00;
   localparam kpg_t KPG_P = 2'b01;
   localparam kpg_t KPG_G = 2'b10;

   // A propagating upper span inherits the status of the lower span.
   function automatic kpg_t kpg_o(input kpg_t hi, input kpg_t lo);
      return (hi == KPG_P) ? lo : hi;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rda_pipe_adder_if.sv
// Operand/result stream bundle for rda_pipe_adder.
interface rda_pipe_adder_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/rda_prefix_level.sv
// One combinational recursive-doubling level over WIDTH+1 KPG symbols at distance DIST.
module rda_prefix_level
   import rda_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  kpg_t [WIDTH:0] x_i,
   output kpg_t [WIDTH:0] y_o
);

   for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
      if (i >= DIST) begin : g_op
         assign y_o[i] = kpg_o(x_i[i], x_i[i-DIST]);
      end else begin : g_pass
         assign y_o[i] = x_i[i];
      end
   end

endmodule

// File: rtl/rda_pipe_adder.sv
// Pipelined KPG parallel-prefix adder/subtractor with a collapsing valid/ready chain.
module rda_pipe_adder
   import rda_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int LVL_PER_STG = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   rda_pipe_adder_if.slave  bus
);

   localparam int L = clog2(WIDTH);
   localparam int N = (L + LVL_PER_STG - 1) / LVL_PER_STG;

   typedef kpg_t [WIDTH:0] kvec_t;

   kvec_t            x_q   [0:N];
   logic [WIDTH-1:0] p_q   [0:N];
   kvec_t            stg_d [1:N];
   logic [N:0]       v_q;
   logic [N:0]       rdy;

   logic [WIDTH-1:0] bp;
   logic [WIDTH-1:0] p0_d;
   kvec_t            x0_d;

   // Position 0 carries the carry-in symbol; position i+1 encodes bit i.
   always_comb begin
      bp      = bus.sub ? ~bus.b : bus.b;
      p0_d    = bus.a ^ bp;
      x0_d[0] = (bus.sub | bus.cin) ? KPG_G : KPG_K;
      for (int i = 0; i < WIDTH; i++) begin
         x0_d[i+1] = {bus.a[i] & bp[i], bus.a[i] ^ bp[i]};
      end
   end

   // A stage can accept when it or any stage downstream of it has a hole.
   for (genvar k = 0; k <= N; k++) begin : g_rdy
      assign rdy[k] = bus.out_ready | ~(&v_q[N:k]);
   end

   for (genvar k = 1; k <= N; k++) begin : g_stg
      kvec_t lv [0:LVL_PER_STG];
      assign lv[0] = x_q[k-1];
      for (genvar m = 0; m < LVL_PER_STG; m++) begin : g_lvl
         localparam int J = (k - 1) * LVL_PER_STG + m;
         if (J < L) begin : g_op
            rda_prefix_level #(
               .WIDTH (WIDTH),
               .DIST  (1 << J)
            ) u_lvl (
               .x_i (lv[m]),
               .y_o (lv[m+1])
            );
         end else begin : g_pass
            assign lv[m+1] = lv[m];
         end
      end
      assign stg_d[k] = lv[LVL_PER_STG];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 0; k <= N; k++) begin
            x_q[k] <= '0;
            p_q[k] <= '0;
         end
      end else begin
         if (flush) begin
            v_q <= '0;
         end else begin
            if (rdy[0]) v_q[0] <= bus.in_valid;
            for (int k = 1; k <= N; k++) begin
               if (rdy[k]) v_q[k] <= v_q[k-1];
            end
         end
         if (rdy[0] & bus.in_valid) begin
            x_q[0] <= x0_d;
            p_q[0] <= p0_d;
         end
         for (int k = 1; k <= N; k++) begin
            if (rdy[k] & v_q[k-1]) begin
               x_q[k] <= stg_d[k];
               p_q[k] <= p_q[k-1];
            end
         end
      end
   end

   kvec_t            y;
   logic [WIDTH-1:0] gen_c;
   logic             cout_c;

   // The top symbol still lacks the carry-in span, hence one more combine.
   always_comb begin
      y      = x_q[N];
      cout_c = (kpg_o(y[WIDTH], y[WIDTH-1]) == KPG_G);
      for (int i = 0; i < WIDTH; i++) begin
         gen_c[i] = (y[i] == KPG_G);
      end
      bus.sum  = p_q[N] ^ gen_c;
      bus.cout = cout_c;
      bus.ovf  = gen_c[WIDTH-1] ^ cout_c;
   end

   assign bus.out_valid = v_q[N];
   assign bus.in_ready  = rdy[0];

endmodule

// File: tb/tb_rda_pipe_adder.sv
// Bench for rda_pipe_adder: vector table, scoreboarded random stream, stall/flush/reset sequences.
module tb_rda_pipe_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic flush;

   rda_pipe_adder_if #(.WIDTH(32)) bus ();
   rda_pipe_adder_if #(.WIDTH(8))  bus8 ();
   rda_pipe_adder_if #(.WIDTH(64)) bus64 ();

   rda_pipe_adder #(.WIDTH(32), .LVL_PER_STG(2)) dut (
      .clk (clk), .rst_n (rst_n), .flush (flush), .bus (bus.slave)
   );
   rda_pipe_adder #(.WIDTH(8), .LVL_PER_STG(1)) dut8 (
      .clk (clk), .rst_n (rst_n), .flush (flush), .bus (bus8.slave)
   );
   rda_pipe_adder #(.WIDTH(64), .LVL_PER_STG(6)) dut64 (
      .clk (clk), .rst_n (rst_n), .flush (flush), .bus (bus64.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      res_t        r;
      logic [31:0] bp;
      logic        c;
      logic [32:0] full;
      logic [31:0] low;
      bp   = sub ? ~b : b;
      c    = sub | cin;
      full = {1'b0, a} + {1'b0, bp} + 33'(c);
      low  = {1'b0, a[30:0]} + {1'b0, bp[30:0]} + 32'(c);
      r.sum  = full[31:0];
      r.cout = full[32];
      r.ovf  = low[31] ^ full[32];
      return r;
   endfunction

   // Scoreboard: push on acceptance, pop on consumption.
   res_t q[$];
   int   n_acc = 0;
   int   n_out = 0;
   logic last_acc = 1'b0;

   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         last_acc = 1'b0;
         if (!rst_n) begin
            q.delete();
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got output %h, expected none", bus.sum);
               end else begin
                  e = q.pop_front();
                  check("sb_sum", 64'(bus.sum), 64'(e.sum));
                  check("sb_cout", 64'(bus.cout), 64'(e.cout));
                  check("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
                  n_out++;
               end
            end
            if (flush) begin
               q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
               q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
               n_acc++;
               last_acc = 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t tbl[8];

   // Single op on the selected instance; returns result and accept-to-valid cycle count.
   task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub,
                         output logic [63:0] s, output logic co, output logic ov, output int lat);
      @(posedge clk); #1;
      case (w)
         8:  begin bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; bus8.sub = sub; bus8.in_valid = 1'b1; end
         64: begin bus64.a = a; bus64.b = b; bus64.cin = cin; bus64.sub = sub; bus64.in_valid = 1'b1; end
         default: begin bus.a = a[31:0]; bus.b = b[31:0]; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1; end
      endcase
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus8.in_valid = 1'b0; bus64.in_valid = 1'b0;
      lat = 1;
      while (lat < 20 && !((w == 8) ? bus8.out_valid : (w == 64) ? bus64.out_valid : bus.out_valid)) begin
         @(posedge clk); #1;
         lat++;
      end
      case (w)
         8:       begin s = 64'(bus8.sum);  co = bus8.cout;  ov = bus8.ovf;  end
         64:      begin s = bus64.sum;      co = bus64.cout; ov = bus64.ovf; end
         default: begin s = 64'(bus.sum);   co = bus.cout;   ov = bus.ovf;   end
      endcase
   endtask

   initial begin
      logic [63:0] s;
      logic        co, ov;
      int          lat, a0, o0, cnt, guard;
      logic [31:0] s0;

      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;
      bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.cin = 1'b0; bus64.sub = 1'b0; bus64.out_ready = 1'b1;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[3] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      tbl[4] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      tbl[7] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sum", 64'(bus.sum), 64'd0);
      check("rst_cout", 64'(bus.cout), 64'd0);
      check("rst_ovf", 64'(bus.ovf), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid8", 64'(bus8.out_valid), 64'd0);
      check("rst_out_valid64", 64'(bus64.out_valid), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_op(32, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].cin, tbl[i].sub, s, co, ov, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         check($sformatf("vec%0d_sum", i), s, 64'(tbl[i].sum));
         check($sformatf("vec%0d_cout", i), 64'(co), 64'(tbl[i].cout));
         check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(tbl[i].ovf));
      end

      run_op(8, 64'hFF, 64'h01, 1'b0, 1'b0, s, co, ov, lat);
      check("w8_ripple", {s[61:0], co, ov}, {62'h0, 1'b1, 1'b0});
      run_op(8, 64'h7F, 64'h01, 1'b0, 1'b0, s, co, ov, lat);
      check("w8_ovf", {s[61:0], co, ov}, {62'h80, 1'b0, 1'b1});
      run_op(8, 64'h00, 64'h01, 1'b0, 1'b1, s, co, ov, lat);
      check("w8_sub", {s[61:0], co, ov}, {62'hFF, 1'b0, 1'b0});
      run_op(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, co, ov, lat);
      check("w64_ripple_sum", s, 64'h0);
      check("w64_ripple_flags", {62'h0, co, ov}, {62'h0, 1'b1, 1'b0});
      run_op(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, co, ov, lat);
      check("w64_ovf_sum", s, 64'h8000_0000_0000_0000);
      check("w64_ovf_flags", {62'h0, co, ov}, {62'h0, 1'b0, 1'b1});
      run_op(64, 64'h0, 64'h1, 1'b0, 1'b1, s, co, ov, lat);
      check("w64_sub_sum", s, 64'hFFFF_FFFF_FFFF_FFFF);
      check("w64_sub_flags", {62'h0, co, ov}, {62'h0, 1'b0, 1'b0});

      // Stall: output blocked with continuous input.
      @(posedge clk); #1;
      a0 = n_acc;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.cin = 1'b1; bus.sub = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (last_acc) begin bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom); end
      end
      check("stall_buffered", 64'(n_acc - a0), 64'd4);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      s0 = bus.sum;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_sum_hold", 64'(bus.sum), 64'(s0));
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      cnt = 0;
      while (bus.out_valid && cnt < 20) begin
         cnt++;
         @(posedge clk); #1;
      end
      check("drain_rate", 64'(cnt), 64'd4);

      // Flush with three ops in flight plus a beat offered in the flush cycle.
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
         @(posedge clk); #1;
      end
      flush = 1'b1; bus.a = $urandom;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) cnt++;
      end
      check("flush_no_stale", 64'(cnt), 64'd0);

      // Asynchronous reset in the middle of a stream.
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.a = $urandom; bus.b = $urandom;
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0; bus.in_valid = 1'b0;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_in_ready", 64'(bus.in_ready), 64'd1);
      check("arst_sum", {bus.sum, bus.cout, bus.ovf}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) cnt++;
      end
      check("arst_no_stale", 64'(cnt), 64'd0);

      // Random stream with random back-pressure.
      a0 = n_acc; o0 = n_out; guard = 0;
      while (n_acc - a0 < 1000 && guard < 20000) begin
         @(posedge clk); #1;
         guard++;
         if (!bus.in_valid || last_acc) begin
            bus.in_valid = ($urandom % 4) != 0;
            bus.a = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.b = $urandom; bus.cin = 1'($urandom); bus.sub = 1'($urandom);
         end
         bus.out_ready = ($urandom % 4) != 0;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      cnt = 0;
      while (q.size() != 0 && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("rand_timeout", 64'(guard >= 20000), 64'd0);
      check("rand_drained", 64'(q.size()), 64'd0);
      check("rand_count", 64'(n_out - o0), 64'(n_acc - a0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
